// File: rtl/ifft_8point_seq.sv
// Iterative 8-point radix-2 inverse FFT: in-place buffer, one shared butterfly
// stepping 3 stages x 4 butterflies, bit-reversed load and natural-order unload.
module ifft_8point_seq #(
   parameter int DATA_W   = 16,
   parameter bit SCALE_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_real,
   input  logic [DATA_W-1:0] in_imag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_real,
   output logic [DATA_W-1:0] out_imag,
   output logic [2:0]        out_index,
   output logic              out_last,
   output logic              busy
);

   localparam logic [1:0] ST_LOAD    = 2'd0;
   localparam logic [1:0] ST_COMPUTE = 2'd1;
   localparam logic [1:0] ST_UNLOAD  = 2'd2;

   localparam int PW = DATA_W + 17;
   localparam int TW = DATA_W + 2;
   localparam int SW = DATA_W + 3;
   localparam logic signed [PW-1:0] RND_C   = PW'(16'sd16384);
   localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(DATA_W-1){1'b1}}});
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   // Conjugate twiddles e^{+j2pi m/8} in Q1.15, packed {re, im}
   function automatic logic [31:0] twiddle(input logic [1:0] m);
      logic [31:0] w;
      case (m)
         2'd0:    w = {16'h7FFF, 16'h0000};
         2'd1:    w = {16'h5A82, 16'h5A82};
         2'd2:    w = {16'h0000, 16'h7FFF};
         2'd3:    w = {16'hA57E, 16'h5A82};
         default: w = {16'h7FFF, 16'h0000};
      endcase
      return w;
   endfunction

   // Bring a butterfly sum back to DATA_W: halve (floor) or saturate
   function automatic logic [DATA_W-1:0] fold(input logic signed [SW-1:0] v);
      logic [DATA_W-1:0] r;
      if (SCALE_EN)
         r = v[DATA_W:1];
      else if (v > SAT_MAX)
         r = SAT_MAX[DATA_W-1:0];
      else if (v < SAT_MIN)
         r = SAT_MIN[DATA_W-1:0];
      else
         r = v[DATA_W-1:0];
      return r;
   endfunction

   logic [1:0]               state_r;
   logic [2:0]               in_cnt_r;
   logic [1:0]               stage_r;
   logic [1:0]               bfly_r;
   logic [2:0]               rd_r;
   logic                     in_ready_r, busy_r, out_valid_r, out_last_r;
   logic [DATA_W-1:0]        out_real_r, out_imag_r;
   logic [2:0]               out_index_r;
   logic signed [DATA_W-1:0] mem_re_r [0:7];
   logic signed [DATA_W-1:0] mem_im_r [0:7];

   logic [2:0]               ia_s, ib_s;
   logic [1:0]               tm_s;
   logic [31:0]              w_s;
   logic signed [15:0]       wr_s, wi_s;
   logic signed [DATA_W-1:0] ar_s, ai_s, br_s, bi_s;
   logic signed [PW-1:0]     pr_s, pi_s;
   logic signed [TW-1:0]     tr_s, ti_s;
   logic signed [SW-1:0]     sr_s, si_s, dr_s, di_s;
   logic [DATA_W-1:0]        nar_s, nai_s, nbr_s, nbi_s;

   // Pair addresses and twiddle index for the current (stage, butterfly)
   always_comb begin
      ia_s = 3'd0;
      ib_s = 3'd0;
      tm_s = 2'd0;
      case (stage_r)
         2'd0: begin
            ia_s = {bfly_r, 1'b0};
            ib_s = {bfly_r, 1'b1};
            tm_s = 2'd0;
         end
         2'd1: begin
            ia_s = {bfly_r[1], 1'b0, bfly_r[0]};
            ib_s = {bfly_r[1], 1'b1, bfly_r[0]};
            tm_s = {bfly_r[0], 1'b0};
         end
         2'd2: begin
            ia_s = {1'b0, bfly_r};
            ib_s = {1'b1, bfly_r};
            tm_s = bfly_r;
         end
         default: begin
            ia_s = 3'd0;
            ib_s = 3'd0;
            tm_s = 2'd0;
         end
      endcase
   end

   // Shared butterfly: t = B*W rounded to TW bits, then A+t / A-t
   always_comb begin
      w_s   = twiddle(tm_s);
      wr_s  = w_s[31:16];
      wi_s  = w_s[15:0];
      ar_s  = mem_re_r[ia_s];
      ai_s  = mem_im_r[ia_s];
      br_s  = mem_re_r[ib_s];
      bi_s  = mem_im_r[ib_s];
      pr_s  = PW'(br_s) * PW'(wr_s) - PW'(bi_s) * PW'(wi_s);
      pi_s  = PW'(br_s) * PW'(wi_s) + PW'(bi_s) * PW'(wr_s);
      tr_s  = TW'((pr_s + RND_C) >>> 15);
      ti_s  = TW'((pi_s + RND_C) >>> 15);
      sr_s  = SW'(ar_s) + SW'(tr_s);
      si_s  = SW'(ai_s) + SW'(ti_s);
      dr_s  = SW'(ar_s) - SW'(tr_s);
      di_s  = SW'(ai_s) - SW'(ti_s);
      nar_s = fold(sr_s);
      nai_s = fold(si_s);
      nbr_s = fold(dr_s);
      nbi_s = fold(di_s);
   end

   // Sample buffer: bit-reversed load, in-place butterfly write-back (not reset)
   always_ff @(posedge clk) begin
      if (state_r == ST_LOAD && in_valid) begin
         mem_re_r[{in_cnt_r[0], in_cnt_r[1], in_cnt_r[2]}] <= in_real;
         mem_im_r[{in_cnt_r[0], in_cnt_r[1], in_cnt_r[2]}] <= in_imag;
      end else if (state_r == ST_COMPUTE) begin
         mem_re_r[ia_s] <= nar_s;
         mem_im_r[ia_s] <= nai_s;
         mem_re_r[ib_s] <= nbr_s;
         mem_im_r[ib_s] <= nbi_s;
      end
   end

   // Frame sequencing and registered output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_LOAD;
         in_cnt_r    <= 3'd0;
         stage_r     <= 2'd0;
         bfly_r      <= 2'd0;
         rd_r        <= 3'd0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_real_r  <= '0;
         out_imag_r  <= '0;
         out_index_r <= 3'd0;
      end else begin
         case (state_r)
            ST_LOAD: begin
               if (in_valid) begin
                  in_cnt_r <= in_cnt_r + 3'd1;
                  if (in_cnt_r == 3'd7) begin
                     state_r    <= ST_COMPUTE;
                     in_ready_r <= 1'b0;
                     busy_r     <= 1'b1;
                     stage_r    <= 2'd0;
                     bfly_r     <= 2'd0;
                  end
               end
            end
            ST_COMPUTE: begin
               bfly_r <= bfly_r + 2'd1;
               if (bfly_r == 2'd3) begin
                  if (stage_r == 2'd2) begin
                     state_r <= ST_UNLOAD;
                     stage_r <= 2'd0;
                     rd_r    <= 3'd0;
                  end else begin
                     stage_r <= stage_r + 2'd1;
                  end
               end
            end
            ST_UNLOAD: begin
               // First pass primes the output register; later passes need a transfer
               if (!out_valid_r || out_ready) begin
                  if (out_valid_r && out_last_r) begin
                     state_r     <= ST_LOAD;
                     in_ready_r  <= 1'b1;
                     busy_r      <= 1'b0;
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                  end else begin
                     out_real_r  <= mem_re_r[rd_r];
                     out_imag_r  <= mem_im_r[rd_r];
                     out_index_r <= rd_r;
                     out_last_r  <= (rd_r == 3'd7);
                     out_valid_r <= 1'b1;
                     rd_r        <= rd_r + 3'd1;
                  end
               end
            end
            default: begin
               state_r     <= ST_LOAD;
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign out_real  = out_real_r;
   assign out_imag  = out_imag_r;
   assign out_index = out_index_r;

endmodule

// File: tb/tb_ifft_8point_seq.sv
// Directed bench for ifft_8point_seq: impulse, DC, tone, full-scale, backpressure
// and reset during compute, against hand-computed Q1.15 results.
module tb_ifft_8point_seq;

   logic        clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
   logic [15:0] in_real, in_imag, out_real, out_imag;
   logic [2:0]  out_index;

   logic [15:0] xr [8];
   logic [15:0] xi [8];
   int          er [8];
   int          ei [8];
   int          et [8];
   int          gr [8];
   int          gi [8];
   int          checks = 0;
   int          errors = 0;

   ifft_8point_seq #(.DATA_W(16), .SCALE_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
      .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
      .out_index(out_index), .out_last(out_last), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int got, input int exp, input int tol);
      int d;
      checks++;
      d = got - exp;
      if (d > tol || d < -tol) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   task automatic clear_frame();
      for (int k = 0; k < 8; k++) begin
         xr[k] = 16'h0000;
         xi[k] = 16'h0000;
         er[k] = 0;
         ei[k] = 0;
         et[k] = 0;
      end
   endtask

   // Called at a negedge while in LOAD; returns at the negedge after the 8th transfer
   task automatic send_frame();
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_real  = xr[k];
         in_imag  = xi[k];
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_real  = 16'h0000;
      in_imag  = 16'h0000;
   endtask

   task automatic recv_frame(input int stall_at);
      int lat;
      int n;
      int guard;
      lat = 0;
      out_ready = 1'b1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, 13, 0);
      n = 0;
      guard = 0;
      while (n < 8 && guard < 100) begin
         if (out_valid) begin
            if (n == stall_at) begin
               out_ready = 1'b0;
               for (int c = 0; c < 5; c++) begin
                  @(negedge clk);
                  chk("stall_valid", int'(out_valid), 1, 0);
                  chk("stall_index", int'(out_index), n, 0);
                  chk("stall_last", int'(out_last), 0, 0);
                  chk("stall_re", $signed(out_real), er[n], et[n]);
                  chk("stall_im", $signed(out_imag), ei[n], et[n]);
                  chk("stall_in_ready", int'(in_ready), 0, 0);
               end
               out_ready = 1'b1;
            end
            chk($sformatf("index%0d", n), int'(out_index), n, 0);
            chk($sformatf("last%0d", n), int'(out_last), (n == 7) ? 1 : 0, 0);
            chk($sformatf("in_ready_out%0d", n), int'(in_ready), 0, 0);
            gr[n] = $signed(out_real);
            gi[n] = $signed(out_imag);
            n++;
         end
         @(negedge clk);
         guard++;
      end
      chk("recv_count", n, 8, 0);
      chk("end_valid", int'(out_valid), 0, 0);
      chk("end_in_ready", int'(in_ready), 1, 0);
      chk("end_busy", int'(busy), 0, 0);
   endtask

   task automatic compare(input string pfx);
      for (int n = 0; n < 8; n++) begin
         chk($sformatf("%s_re%0d", pfx, n), gr[n], er[n], et[n]);
         chk($sformatf("%s_im%0d", pfx, n), gi[n], ei[n], et[n]);
      end
   endtask

   task automatic setup_impulse();
      clear_frame();
      xr[0] = 16'h7FFF;
      for (int n = 0; n < 8; n++) er[n] = 4095;
   endtask

   task automatic setup_tone();
      clear_frame();
      xr[1] = 16'h4000;
      er[0] = 2048;  ei[0] = 0;
      er[1] = 1448;  ei[1] = 1448;
      er[2] = 0;     ei[2] = 2048;
      er[3] = -1448; ei[3] = 1448;
      er[4] = -2048; ei[4] = 0;
      er[5] = -1448; ei[5] = -1448;
      er[6] = 0;     ei[6] = -2048;
      er[7] = 1448;  ei[7] = -1448;
      for (int n = 0; n < 8; n++) et[n] = 2;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_real   = 16'h0000;
      in_imag   = 16'h0000;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1, 0);
      chk("rst_out_valid", int'(out_valid), 0, 0);
      chk("rst_busy", int'(busy), 0, 0);
      chk("rst_out_real", int'(out_real), 0, 0);
      chk("rst_out_index", int'(out_index), 0, 0);
      chk("rst_out_last", int'(out_last), 0, 0);
      rst = 1'b0;
      @(negedge clk);

      setup_impulse();
      send_frame();
      chk("compute_in_ready", int'(in_ready), 0, 0);
      chk("compute_busy", int'(busy), 1, 0);
      recv_frame(-1);
      compare("imp");

      clear_frame();
      for (int k = 0; k < 8; k++) xr[k] = 16'h1000;
      er[0] = 4096;
      for (int n = 1; n < 8; n++) et[n] = 1;
      send_frame();
      recv_frame(-1);
      compare("dc");

      setup_tone();
      send_frame();
      recv_frame(-1);
      compare("tone");

      clear_frame();
      for (int k = 0; k < 8; k++) xr[k] = 16'h8000;
      er[0] = -32768;
      for (int n = 1; n < 8; n++) et[n] = 2;
      send_frame();
      recv_frame(-1);
      compare("fs");

      setup_tone();
      send_frame();
      recv_frame(3);
      compare("bp");

      setup_impulse();
      send_frame();
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", int'(in_ready), 1, 0);
      chk("midrst_out_valid", int'(out_valid), 0, 0);
      chk("midrst_busy", int'(busy), 0, 0);
      rst = 1'b0;
      @(negedge clk);
      setup_impulse();
      send_frame();
      recv_frame(-1);
      compare("imp2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
